bp_nonsynth_cosim_commit_arbiter: RTL and testbench



---
 rtl/bp_nonsynth_cosim_commit_arbiter_if.sv | 36 +++
 rtl/bp_nonsynth_cosim_commit_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bp_nonsynth_cosim_commit_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bp_nonsynth_cosim_commit_arbiter_if.sv
// Purpose: commit-queue / DPI-step bundle between the per-core cosim commit
//          FIFOs, the commit arbiter and the shared DPI step/trap caller.
// Signals:
//   req_v/req_trap/req_data  per-core head record (core i at slice i)
//   req_yumi                 one-hot dequeue of a core's head record
//   step_v/step_core/step_trap/step_data  serialized output slot
//   step_ready               consumer accepts the slot this cycle
//   mismatch                 consumer model mismatch, valid with an accept
// Modports: master = queues + consumer side, slave = arbiter side.
interface bp_nonsynth_cosim_commit_arbiter_if #(
   parameter int unsigned num_core_p   = 4,
   parameter int unsigned data_width_p = 128
);
   localparam int unsigned core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

   logic [num_core_p-1:0]              req_v;
   logic [num_core_p-1:0]              req_trap;
   logic [num_core_p*data_width_p-1:0] req_data;
   logic [num_core_p-1:0]              req_yumi;
   logic                               step_v;
   logic [core_width_lp-1:0]           step_core;
   logic                               step_trap;
   logic [data_width_p-1:0]            step_data;
   logic                               step_ready;
   logic                               mismatch;

   modport master (
      output req_v, req_trap, req_data, step_ready, mismatch,
      input  req_yumi, step_v, step_core, step_trap, step_data
   );

   modport slave (
      input  req_v, req_trap, req_data, step_ready, mismatch,
      output req_yumi, step_v, step_core, step_trap, step_data
   );
endinterface

// File: rtl/bp_nonsynth_cosim_commit_arbiter.sv
// Purpose: serializes commit/trap records from num_core_p cosim commit queues
//          onto one DPI stepping slot (round-robin, per-core retire cap,
//          done/fail sequencing, stall watchdog).
// Ports:
//   clk_i        clock, posedge
//   reset_i      asynchronous, active-low reset
//   en_i         arbitration enable (0 = no grants, slot still drains)
//   instr_cap_i  per-core retire cap, 0 = unlimited
//   arb_bus      commit queue / step slot bundle (slave modport)
//   done_o       all cores capped and slot drained (sticky)
//   fail_o       consumer mismatch seen (sticky)
//   starve_o     slot backpressured for starve_limit_p cycles (sticky)
// Optional feature: define BP_COSIM_ARB_TRAP_PRIORITY_EN to arbitrate among
//   trap-carrying eligible cores first whenever any exist.
module bp_nonsynth_cosim_commit_arbiter #(
   parameter int unsigned num_core_p     = 4,
   parameter int unsigned data_width_p   = 128,
   parameter int unsigned cnt_width_p    = 32,
   parameter int unsigned starve_limit_p = 1024
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  en_i,
   input  logic [cnt_width_p-1:0]                instr_cap_i,
   bp_nonsynth_cosim_commit_arbiter_if.slave     arb_bus,
   output logic                                  done_o,
   output logic                                  fail_o,
   output logic                                  starve_o
);
   localparam int unsigned core_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
   localparam int unsigned wd_width_lp   = $clog2(starve_limit_p + 1);

   typedef enum logic [1:0] {e_run, e_done, e_fail} state_e;

   state_e                   r_state, w_state_n;
   logic [core_width_lp-1:0] r_rr;
   logic [cnt_width_p-1:0]   r_retired [num_core_p];
   logic [wd_width_lp-1:0]   r_wd;
   logic                     r_step_v, r_step_trap;
   logic [core_width_lp-1:0] r_step_core;
   logic [data_width_p-1:0]  r_step_data;
   logic                     r_done, r_fail, r_starve;

   logic [num_core_p-1:0]    w_mask, w_elig, w_cand;
   logic                     w_cap_en, w_slot_free, w_accept, w_bad_accept;
   logic                     w_grant_v, w_done_cond, w_found;
   logic [core_width_lp-1:0] w_grant_idx;

   // Cores that have retired up to the cap are excluded, traps included.
   assign w_cap_en = (instr_cap_i != '0);
   always_comb begin
      w_mask = '0;
      for (int unsigned i = 0; i < num_core_p; i++) begin
         w_mask[i] = w_cap_en && (r_retired[i] >= instr_cap_i);
      end
   end

   assign w_elig = arb_bus.req_v & ~w_mask;

`ifdef BP_COSIM_ARB_TRAP_PRIORITY_EN
   assign w_cand = (|(w_elig & arb_bus.req_trap)) ? (w_elig & arb_bus.req_trap) : w_elig;
`else
   assign w_cand = w_elig;
`endif

   // First candidate at or after the rr pointer, wrapping.
   always_comb begin
      int unsigned idx;
      idx         = 0;
      w_found     = 1'b0;
      w_grant_idx = '0;
      for (int unsigned off = 0; off < num_core_p; off++) begin
         idx = 32'(r_rr) + off;
         if (idx >= num_core_p) idx = idx - num_core_p;
         if (!w_found && w_cand[core_width_lp'(idx)]) begin
            w_found     = 1'b1;
            w_grant_idx = core_width_lp'(idx);
         end
      end
   end

   assign w_slot_free  = ~r_step_v | arb_bus.step_ready;
   assign w_accept     = r_step_v & arb_bus.step_ready;
   assign w_bad_accept = w_accept & arb_bus.mismatch;

   // No dequeue while in reset or on the failing accept: those records would be lost.
   assign w_grant_v = reset_i & (r_state == e_run) & en_i & w_slot_free & w_found & ~w_bad_accept;

   assign w_done_cond = w_cap_en & (&w_mask) & (~r_step_v | (w_accept & ~arb_bus.mismatch));

   assign arb_bus.req_yumi = w_grant_v ? (num_core_p'(1) << w_grant_idx) : '0;

   // FSM state register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= e_run;
      else          r_state <= w_state_n;
   end

   // FSM next state; failure wins over completion, both terminal.
   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         e_run: begin
            if (w_bad_accept)     w_state_n = e_fail;
            else if (w_done_cond) w_state_n = e_done;
         end
         default: w_state_n = r_state;
      endcase
   end

   // Output slot, rr pointer and sticky status flags.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_step_v    <= 1'b0;
         r_step_trap <= 1'b0;
         r_step_core <= '0;
         r_step_data <= '0;
         r_rr        <= '0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         r_done <= (w_state_n == e_done);
         r_fail <= (w_state_n == e_fail);
         if (w_grant_v) begin
            r_step_v    <= 1'b1;
            r_step_core <= w_grant_idx;
            r_step_trap <= arb_bus.req_trap[w_grant_idx];
            r_step_data <= arb_bus.req_data[32'(w_grant_idx)*data_width_p +: data_width_p];
            r_rr        <= (32'(w_grant_idx) + 32'd1 >= num_core_p) ? '0
                                                                    : core_width_lp'(w_grant_idx + core_width_lp'(1));
         end else if (arb_bus.step_ready) begin
            r_step_v <= 1'b0;
         end
      end
   end

   // Per-core retired counters; traps are not retirements. Saturating.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int unsigned i = 0; i < num_core_p; i++) r_retired[i] <= '0;
      end else if (w_grant_v && !arb_bus.req_trap[w_grant_idx] && (r_retired[w_grant_idx] != '1)) begin
         r_retired[w_grant_idx] <= r_retired[w_grant_idx] + cnt_width_p'(1);
      end
   end

   // Stall watchdog: counts backpressured cycles, cleared by an accept.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wd     <= '0;
         r_starve <= 1'b0;
      end else if (w_accept) begin
         r_wd <= '0;
      end else if (r_step_v) begin
         if (r_wd < wd_width_lp'(starve_limit_p)) r_wd <= r_wd + wd_width_lp'(1);
         if (r_wd >= wd_width_lp'(starve_limit_p - 1)) r_starve <= 1'b1;
      end
   end

   assign arb_bus.step_v    = r_step_v;
   assign arb_bus.step_core = r_step_core;
   assign arb_bus.step_trap = r_step_trap;
   assign arb_bus.step_data = r_step_data;
   assign done_o            = r_done;
   assign fail_o            = r_fail;
   assign starve_o          = r_starve;
endmodule

// File: tb/tb_bp_nonsynth_cosim_commit_arbiter.sv
// Purpose: directed self-checking bench for bp_nonsynth_cosim_commit_arbiter
//          (4 cores, 16-bit records, 8-bit counters, watchdog limit 8).
module tb_bp_nonsynth_cosim_commit_arbiter;
   localparam int unsigned NC = 4;
   localparam int unsigned DW = 16;

   logic       clk = 1'b0;
   logic       reset_i;
   logic       en;
   logic [7:0] cap;
   logic       done, fail, starve;

   int n_chk = 0;
   int n_err = 0;

   bp_nonsynth_cosim_commit_arbiter_if #(.num_core_p(NC), .data_width_p(DW)) bus ();

   bp_nonsynth_cosim_commit_arbiter #(
      .num_core_p(NC), .data_width_p(DW), .cnt_width_p(8), .starve_limit_p(8)
   ) dut (
      .clk_i(clk), .reset_i(reset_i), .en_i(en), .instr_cap_i(cap),
      .arb_bus(bus), .done_o(done), .fail_o(fail), .starve_o(starve)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b1;
   endtask

   function automatic logic [DW-1:0] rec(input int i);
      return DW'(16'hC000 + i);
   endfunction

   task automatic set_data();
      for (int i = 0; i < NC; i++) bus.req_data[i*DW +: DW] = rec(i);
   endtask

   int          rem  [NC];
   int          gcnt [NC];
   int          accepts, acc12, done_at, tidx;
   logic [3:0]  trap_seq;

   initial begin
      reset_i        = 1'b0;
      en             = 1'b0;
      cap            = '0;
      bus.req_v      = '0;
      bus.req_trap   = '0;
      bus.step_ready = 1'b0;
      bus.mismatch   = 1'b0;
      set_data();
      #2;

      // Reset state
      chk("rst_step_v", 32'(bus.step_v), 0);
      chk("rst_yumi",   32'(bus.req_yumi), 0);
      chk("rst_done",   32'(done), 0);
      chk("rst_fail",   32'(fail), 0);
      chk("rst_starve", 32'(starve), 0);
      do_reset();

      // Round-robin with all cores requesting
      en = 1'b1; bus.step_ready = 1'b1; bus.req_v = 4'hF;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk("rr_yumi", 32'(bus.req_yumi), 32'(1) << (k % 4));
         tick();
         chk("rr_step_v",    32'(bus.step_v), 1);
         chk("rr_step_core", 32'(bus.step_core), 32'(k % 4));
         chk("rr_step_data", 32'(bus.step_data), 32'(rec(k % 4)));
      end
      bus.req_v = '0;
      tick();
      chk("rr_drain", 32'(bus.step_v), 0);

      // Backpressure and watchdog
      bus.step_ready = 1'b0; bus.req_v = 4'b0100;
      #1;
      chk("bp_grant2", 32'(bus.req_yumi), 32'h4);
      tick();
      bus.req_v = 4'b0001;
      bus.req_data[2*DW +: DW] = DW'(16'hDEAD);
      for (int k = 0; k < 10; k++) begin
         #1;
         chk("bp_yumi",   32'(bus.req_yumi), 0);
         chk("bp_core",   32'(bus.step_core), 2);
         chk("bp_data",   32'(bus.step_data), 32'hC002);
         chk("bp_starve", 32'(starve), (k >= 8) ? 1 : 0);
         tick();
      end
      bus.step_ready = 1'b1;
      #1;
      chk("bp_release_yumi", 32'(bus.req_yumi), 32'h1);
      tick();
      chk("bp_next_core",  32'(bus.step_core), 0);
      chk("bp_next_v",     32'(bus.step_v), 1);
      chk("bp_starve_stk", 32'(starve), 1);
      bus.req_v = '0;
      set_data();
      tick();
      chk("bp_empty", 32'(bus.step_v), 0);

      // Cap and done
      do_reset();
      cap = 8'd3; en = 1'b1; bus.step_ready = 1'b1;
      rem = '{5, 5, 3, 3};
      gcnt = '{0, 0, 0, 0};
      accepts = 0; acc12 = -1; done_at = -1;
      for (int c = 0; c < 30; c++) begin
         if (done && done_at < 0) done_at = c;
         for (int i = 0; i < NC; i++) bus.req_v[i] = (rem[i] > 0);
         #1;
         if (bus.step_v && bus.step_ready) begin
            accepts++;
            if (accepts == 12) acc12 = c;
         end
         for (int i = 0; i < NC; i++) if (bus.req_yumi[i]) begin gcnt[i]++; rem[i]--; end
         tick();
      end
      for (int i = 0; i < NC; i++) chk("cap_grants", 32'(gcnt[i]), 3);
      chk("cap_rem0",    32'(rem[0]), 2);
      chk("cap_accept12", 32'(acc12), 12);
      chk("cap_done_at", 32'(done_at), 13);
      chk("cap_done",    32'(done), 1);
      chk("cap_fail",    32'(fail), 0);

      // Trap not counted against the cap
      do_reset();
      cap = 8'd2; en = 1'b1; bus.step_ready = 1'b1;
      trap_seq = 4'b0010;
      tidx = 0;
      for (int c = 0; c < 12; c++) begin
         bus.req_v    = (tidx < 4) ? 4'b0001 : 4'b0000;
         bus.req_trap = (tidx < 4 && trap_seq[tidx]) ? 4'b0001 : 4'b0000;
         #1;
         if (bus.req_yumi[0]) tidx++;
         tick();
      end
      chk("trap_granted", 32'(tidx), 3);
      chk("trap_done",    32'(done), 0);

      // Enable gating
      bus.req_trap = '0; bus.req_v = 4'b0011; en = 1'b0;
      #1;
      chk("en_off_yumi", 32'(bus.req_yumi), 0);
      en = 1'b1;
      #1;
      chk("en_on_yumi", 32'(bus.req_yumi), 32'h2);
      bus.req_v = '0;

      // Mismatch on the 5th accepted slot
      do_reset();
      cap = '0; en = 1'b1; bus.step_ready = 1'b1; bus.req_v = 4'hF;
      for (int c = 0; c < 5; c++) tick();
      bus.mismatch = 1'b1;
      #1;
      chk("mm_slot_core", 32'(bus.step_core), 0);
      chk("mm_yumi",      32'(bus.req_yumi), 0);
      tick();
      bus.mismatch = 1'b0;
      chk("mm_fail",   32'(fail), 1);
      chk("mm_step_v", 32'(bus.step_v), 0);
      chk("mm_done",   32'(done), 0);
      chk("mm_yumi_after", 32'(bus.req_yumi), 0);
      tick();
      chk("mm_fail_sticky", 32'(fail), 1);
      chk("mm_yumi_later",  32'(bus.req_yumi), 0);

      // Async reset in the middle of a stall
      do_reset();
      bus.req_v = 4'b0001; bus.step_ready = 1'b0;
      tick();
      for (int c = 0; c < 8; c++) tick();
      chk("rs_starve_pre", 32'(starve), 1);
      chk("rs_step_v_pre", 32'(bus.step_v), 1);
      #2;
      reset_i = 1'b0;
      #1;
      chk("rs_step_v", 32'(bus.step_v), 0);
      chk("rs_starve", 32'(starve), 0);
      chk("rs_yumi",   32'(bus.req_yumi), 0);
      chk("rs_fail",   32'(fail), 0);
      tick();
      reset_i = 1'b1;

      // Trap precedence (rr pointer at 0 after reset)
      bus.req_v = 4'b1010; bus.req_trap = 4'b1000; bus.step_ready = 1'b1;
      #1;
`ifdef BP_COSIM_ARB_TRAP_PRIORITY_EN
      chk("trap_prio", 32'(bus.req_yumi), 32'h8);
`else
      chk("trap_prio", 32'(bus.req_yumi), 32'h2);
`endif
      bus.req_v = '0; bus.req_trap = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
